// File: rtl/display_driver_7seg_pkg.sv
// Shared types and constants for the 7-segment display driver.
// Holds the converter state encoding, the segment table and the BCD adjust step.
package display_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_t;

    localparam int unsigned HEX_DIGITS = 4;
    localparam int unsigned DEC_DIGITS = 5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex digit value
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/display_driver_7seg_if.sv
// Display-side signal bundle: value/mode in from the display mux, anode/segment pins out.
interface display_driver_7seg_if;

    logic [15:0] value;
    logic        dec_mode;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output value,
        output dec_mode,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  value,
        input  dec_mode,
        output an,
        output seg,
        output dp
    );

endinterface

// File: rtl/display_driver_7seg_bin2bcd.sv
// Free-running sequential double-dabble: LOAD (1) + SHIFT (16) + COMMIT (1) = 18 cycles.
// bcd holds the finished result while done is high (the COMMIT cycle).
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        done
);

    conv_state_t r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [19:0] w_adj;

    assign w_adj = dabble_adjust(r_bcd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_bin   <= bin;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_state <= LOAD;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign done = (r_state == COMMIT);

endmodule

// File: rtl/display_driver_7seg.sv
// 16-bit word to 8-digit multiplexed common-anode 7-segment display, hex or unsigned decimal,
// with leading-zero blanking and registered anode/segment outputs.
module display_driver_7seg
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned N_DIGITS    = 8
) (
    input logic                 clk,
    input logic                 reset,
    display_driver_7seg_if.slave bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [19:0]         w_bcd;
    logic                w_done;
    logic                r_load;
    logic [15:0]         r_hex;
    logic                r_dec_mode;

    logic [3:0]          w_new_digit [N_DIGITS];
    logic [N_DIGITS-1:0] w_valid_new;
    logic                w_any_nz;
    logic                w_in_range;

    logic [3:0]          r_digit [N_DIGITS];
    logic [N_DIGITS-1:0] r_valid;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [3:0]          w_cur_digit;
    logic                w_cur_valid;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (bus.value),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    // r_load tracks the converter's LOAD cycle so hex value and mode are captured alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load     <= 1'b1;
            r_hex      <= '0;
            r_dec_mode <= 1'b0;
        end else begin
            r_load <= w_done;
            if (r_load) begin
                r_hex      <= bus.value;
                r_dec_mode <= bus.dec_mode;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            w_new_digit[i] = '0;
        end
        for (int unsigned i = 0; i < HEX_DIGITS; i++) begin
            w_new_digit[i] = r_dec_mode ? w_bcd[4*i +: 4] : r_hex[4*i +: 4];
        end
        if (r_dec_mode) begin
            w_new_digit[DEC_DIGITS-1] = w_bcd[4*(DEC_DIGITS-1) +: 4];
        end

        // Scan from the top digit down so a nonzero digit lights everything below it
        w_any_nz    = 1'b0;
        w_in_range  = 1'b0;
        w_valid_new = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            w_in_range = r_dec_mode ? ((N_DIGITS - 1 - k) < DEC_DIGITS)
                                    : ((N_DIGITS - 1 - k) < HEX_DIGITS);
            w_any_nz   = w_any_nz | (w_in_range && (w_new_digit[N_DIGITS-1-k] != 4'd0));
            w_valid_new[N_DIGITS-1-k] = w_in_range && w_any_nz;
        end
        w_valid_new[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= '{default: '0};
            r_valid <= N_DIGITS'(1);
        end else if (w_done) begin
            r_digit <= w_new_digit;
            r_valid <= w_valid_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_cur_digit = r_digit[r_idx];
    assign w_cur_valid = r_valid[r_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_cur_valid ? ~(N_DIGITS'(1) << r_idx) : '1;
            r_seg <= w_cur_valid ? SEG_LUT[w_cur_digit] : SEG_BLANK;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_display_driver_7seg.sv
// Scoreboard bench: stimulus queues expected display frames, a monitor checks observation windows.
module tb_display_driver_7seg;

    localparam int RD   = 4;
    localparam int FULL = 8 * RD;

    localparam logic [6:0] SEG_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7:0]  valid;
        logic [55:0] segs;
    } frame_t;

    typedef struct {
        int     start;
        int     len;
        frame_t f;
        string  name;
    } win_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    bit   mon_active = 1'b0;
    win_t q[$];

    display_driver_7seg_if bus ();

    display_driver_7seg #(
        .REFRESH_DIV (RD),
        .N_DIGITS    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Expected digits from plain radix arithmetic; digit i shows iff value >= base**i (digit 0 always)
    function automatic frame_t model(input logic [15:0] v, input bit dm);
        frame_t f;
        int vi;
        int base;
        int nd;
        int p;
        int dg;
        vi     = int'(v);
        base   = dm ? 10 : 16;
        nd     = dm ? 5 : 4;
        p      = 1;
        f.valid = '0;
        f.segs  = {8{7'h7F}};
        for (int i = 0; i < nd; i++) begin
            dg = (vi / p) % base;
            f.segs[7*i +: 7] = SEG_REF[dg];
            f.valid[i] = (i == 0) || (vi >= p);
            p = p * base;
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_win(input int start, input int len, input logic [15:0] v, input bit dm,
                            input string name);
        win_t w;
        w.start = start;
        w.len   = len;
        w.f     = model(v, dm);
        w.name  = name;
        q.push_back(w);
    endtask

    initial begin : monitor
        win_t        cur;
        int          lit [8];
        bit          badseg [8];
        int          bad_shape;
        int          remaining;
        int          zeros;
        int          d;
        int          exp_lit;
        bit          ok;
        logic [7:0]  an_s;
        logic [6:0]  seg_s;
        remaining = 0;
        bad_shape = 0;
        forever begin
            @(negedge clk);
            if (!mon_active && q.size() > 0 && !reset && cyc == q[0].start) begin
                cur        = q.pop_front();
                mon_active = 1'b1;
                remaining  = cur.len;
                bad_shape  = 0;
                for (int k = 0; k < 8; k++) begin
                    lit[k]    = 0;
                    badseg[k] = 1'b0;
                end
            end else if (!mon_active && q.size() > 0 && !reset && cyc > q[0].start) begin
                checks++;
                errors++;
                $display("FAIL %s: window missed at cycle %0d, start %0d", q[0].name, cyc, q[0].start);
                q.delete(0);
            end
            if (mon_active) begin
                an_s  = bus.an;
                seg_s = bus.seg;
                if (an_s == 8'hFF) begin
                    if (seg_s != 7'h7F) bad_shape++;
                end else begin
                    zeros = 0;
                    d     = 0;
                    for (int k = 0; k < 8; k++) begin
                        if (!an_s[k]) begin
                            zeros++;
                            d = k;
                        end
                    end
                    if (zeros != 1) begin
                        bad_shape++;
                    end else begin
                        lit[d]++;
                        if (seg_s != cur.f.segs[7*d +: 7]) badseg[d] = 1'b1;
                    end
                end
                remaining--;
                if (remaining == 0) begin
                    mon_active = 1'b0;
                    checks++;
                    if (bad_shape != 0) begin
                        errors++;
                        $display("FAIL %s shape: %0d bad an/seg cycles, expected 0", cur.name, bad_shape);
                    end
                    for (int k = 0; k < 8; k++) begin
                        ok      = !badseg[k];
                        exp_lit = cur.f.valid[k] ? RD : 0;
                        if (cur.len == FULL)       ok = ok && (lit[k] == exp_lit);
                        else if (!cur.f.valid[k])  ok = ok && (lit[k] == 0);
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL %s digit%0d: lit %0d cycles seg_wrong=%0d, expected lit %0d seg %h",
                                     cur.name, k, lit[k], badseg[k], exp_lit, cur.f.segs[7*k +: 7]);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] dv  [9] = '{16'h00A5, 16'hFFFF, 16'hFFFF, 16'd1000, 16'h0000,
                                 16'd9, 16'd10, 16'h000F, 16'h0010};
        bit          dmv [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] v;
        logic [31:0] r;
        bit          dm;

        reset        = 1'b1;
        bus.value    = 16'h0000;
        bus.dec_mode = 1'b0;
        push_win(2, FULL, 16'h0000, 1'b0, "reset_frame");
        repeat (3) @(negedge clk);
        check("reset_an", bus.an, 8'hFF);
        check("reset_seg", bus.seg, 7'h7F);
        reset = 1'b0;
        @(negedge clk);
        check("rel_an", bus.an, 8'hFE);
        check("rel_seg", bus.seg, 7'h40);
        check("rel_dp", bus.dp, 1'b1);

        while (cyc < 34) @(negedge clk);
        bus.value = 16'h1234;
        // Scan index 5 and converter mid-SHIFT at this point
        while (cyc < 85) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_an", bus.an, 8'hFF);
        check("midrst_seg", bus.seg, 7'h7F);

        push_win(5, 14, 16'h0000, 1'b0, "post_rst_digits");
        push_win(19, 18, 16'h1234, 1'b0, "first_commit");
        push_win(37, FULL, 16'h5678, 1'b0, "second_commit");
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_an_k1", bus.an, 8'hFE);
        check("post_rst_seg_k1", bus.seg, 7'h40);
        @(negedge clk);
        @(negedge clk);
        bus.value = 16'h5678;
        @(negedge clk);
        check("post_rst_an_k4", bus.an, 8'hFE);
        @(negedge clk);
        check("post_rst_an_k5", bus.an, 8'hFF);
        while (cyc < 69) @(negedge clk);

        for (int n = 0; n < 25; n++) begin
            if (n < 9) begin
                v  = dv[n];
                dm = dmv[n];
            end else begin
                r  = $urandom;
                v  = r[15:0] >> $urandom_range(0, 15);
                dm = 1'($urandom_range(0, 1));
            end
            repeat ($urandom_range(0, 17)) @(negedge clk);
            bus.value    = v;
            bus.dec_mode = dm;
            repeat (37) @(negedge clk);
            push_win(cyc + 1, FULL, v, dm, $sformatf("case%0d_%h_%0d", n, v, dm));
            repeat (34) @(negedge clk);
        end

        for (int t = 0; t < 200 && (q.size() > 0 || mon_active); t++) @(negedge clk);
        if (q.size() > 0 || mon_active) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d windows pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
